toy_vdispatch: RTL and testbench

//  In-order, single-issue vector dispatch stage directly upstream of the vector element (toy_velement).

---
 rtl/toy_vdispatch.sv | 248 ++++++++++++++++++++++++
 tb/tb_toy_vdispatch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_vdispatch.sv
// In-order single-issue vector dispatch: instruction FIFO, per-register countdown scoreboard, registered op buses.
// Optional perf counters are compiled in when TOY_VDISPATCH_PERF_EN is defined.
module toy_vdispatch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OPC_W      = 8,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned ALU_LAT    = 2,
  parameter int unsigned LSU_LAT    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_unit,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [IDX_W-1:0] in_vs1,
  input  logic [IDX_W-1:0] in_vs2,
  input  logic [IDX_W-1:0] in_rd,
  input  logic             in_rd_wr,
  input  logic             flush,
  output logic             vmtx_op_en,
  output logic [OPC_W-1:0] vmtx_opcode,
  output logic [IDX_W-1:0] vmtx_vs1,
  output logic [IDX_W-1:0] vmtx_vs2,
  output logic             valu_op_en,
  output logic [OPC_W-1:0] valu_opcode,
  output logic [IDX_W-1:0] valu_vs1,
  output logic [IDX_W-1:0] valu_vs2,
  output logic [IDX_W-1:0] valu_rd,
  output logic             vlsu_op_en,
  output logic [OPC_W-1:0] vlsu_opcode,
  output logic [IDX_W-1:0] vlsu_vs1,
  output logic [IDX_W-1:0] vlsu_vs2,
  output logic [IDX_W-1:0] vlsu_rd,
  output logic             illegal_err,
  output logic             busy
`ifdef TOY_VDISPATCH_PERF_EN
  ,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_LAT  = (ALU_LAT > LSU_LAT) ? ALU_LAT : LSU_LAT;
  localparam int unsigned CNT_W    = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int unsigned NUM_REGS = 1 << IDX_W;

  localparam logic [1:0] UNIT_MTX = 2'd0;
  localparam logic [1:0] UNIT_ALU = 2'd1;
  localparam logic [1:0] UNIT_ILL = 2'd3;

  typedef struct packed {
    logic [1:0]       unit;
    logic [OPC_W-1:0] opcode;
    logic [IDX_W-1:0] vs1;
    logic [IDX_W-1:0] vs2;
    logic [IDX_W-1:0] rd;
    logic             rd_wr;
  } instr_t;

  instr_t             fifo_mem [FIFO_DEPTH];
  instr_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_n;
  logic [CNT_W-1:0]   sb_cnt   [NUM_REGS];
  logic [CNT_W-1:0]   sb_cnt_n [NUM_REGS];
  logic [NUM_REGS-1:0] sb_busy;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               hazard;
  logic               issue_mtx;
  logic               issue_alu;
  logic               issue_lsu;
  logic               drop_ill;
  logic               any_pending;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign head     = fifo_mem[rd_ptr];

  // Register 0 is hardwired never-busy.
  always_comb begin
    sb_busy = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      sb_busy[IDX_W'(i)] = (sb_cnt[IDX_W'(i)] != '0);
    end
  end

  // Issue decision on the FIFO head.
  always_comb begin
    pop       = 1'b0;
    issue_mtx = 1'b0;
    issue_alu = 1'b0;
    issue_lsu = 1'b0;
    drop_ill  = 1'b0;
    hazard    = sb_busy[head.vs1] || sb_busy[head.vs2] ||
                ((head.unit != UNIT_MTX) && head.rd_wr && sb_busy[head.rd]);
    if (!empty && !flush) begin
      if (head.unit == UNIT_ILL) begin
        pop      = 1'b1;
        drop_ill = 1'b1;
      end else if (!hazard) begin
        pop = 1'b1;
        case (head.unit)
          UNIT_MTX: issue_mtx = 1'b1;
          UNIT_ALU: issue_alu = 1'b1;
          default:  issue_lsu = 1'b1;
        endcase
      end
    end
  end

  // Countdown scoreboard: decrement all, then load the issuing writer's latency.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sb_cnt_n[IDX_W'(i)] = (sb_cnt[IDX_W'(i)] != '0) ? sb_cnt[IDX_W'(i)] - CNT_W'(1) : '0;
    end
    if ((issue_alu || issue_lsu) && head.rd_wr && (head.rd != '0)) begin
      sb_cnt_n[head.rd] = issue_alu ? CNT_W'(ALU_LAT) : CNT_W'(LSU_LAT);
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      any_pending = any_pending || (sb_cnt_n[IDX_W'(i)] != '0);
    end
  end

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else if (push && !pop) begin
      count_n = count + (PTR_W+1)'(1);
    end else if (!push && pop) begin
      count_n = count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{unit: in_unit, opcode: in_opcode, vs1: in_vs1,
                            vs2: in_vs2, rd: in_rd, rd_wr: in_rd_wr};
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) sb_cnt[IDX_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) sb_cnt[IDX_W'(i)] <= sb_cnt_n[IDX_W'(i)];
    end
  end

  // Op buses: enables pulse per issue, fields hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vmtx_op_en  <= 1'b0;
      vmtx_opcode <= '0;
      vmtx_vs1    <= '0;
      vmtx_vs2    <= '0;
      valu_op_en  <= 1'b0;
      valu_opcode <= '0;
      valu_vs1    <= '0;
      valu_vs2    <= '0;
      valu_rd     <= '0;
      vlsu_op_en  <= 1'b0;
      vlsu_opcode <= '0;
      vlsu_vs1    <= '0;
      vlsu_vs2    <= '0;
      vlsu_rd     <= '0;
      illegal_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vmtx_op_en  <= issue_mtx;
      valu_op_en  <= issue_alu;
      vlsu_op_en  <= issue_lsu;
      illegal_err <= drop_ill;
      busy        <= (count_n != '0) || any_pending;
      if (issue_mtx) begin
        vmtx_opcode <= head.opcode;
        vmtx_vs1    <= head.vs1;
        vmtx_vs2    <= head.vs2;
      end
      if (issue_alu) begin
        valu_opcode <= head.opcode;
        valu_vs1    <= head.vs1;
        valu_vs2    <= head.vs2;
        valu_rd     <= head.rd;
      end
      if (issue_lsu) begin
        vlsu_opcode <= head.opcode;
        vlsu_vs1    <= head.vs1;
        vlsu_vs2    <= head.vs2;
        vlsu_rd     <= head.rd;
      end
    end
  end

`ifdef TOY_VDISPATCH_PERF_EN
  logic issue_any;
  logic stall;

  assign issue_any = issue_mtx || issue_alu || issue_lsu;
  assign stall     = !empty && !flush && (head.unit != UNIT_ILL) && hazard;

  // Saturating perf counters, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (flush) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue_any && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (stall && (perf_stall_cnt != '1))     perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_toy_vdispatch.sv
// Bench for toy_vdispatch: directed vector table, hand-written corner sequences, and random
// traffic checked every cycle against a queue / ready-time reference model.
module tb_toy_vdispatch;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned LSU_LAT = 3;

  typedef struct packed {
    logic [1:0] unit;
    logic [7:0] opc;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [4:0] rd;
    logic       wr;
  } instr_t;

  typedef struct {
    bit     v;
    instr_t in;
    bit     fl;
    bit     e_rdy, e_mtx, e_alu, e_lsu, e_ill, e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_rd_wr, flush;
  logic [1:0] in_unit;
  logic [7:0] in_opcode;
  logic [4:0] in_vs1, in_vs2, in_rd;
  logic vmtx_op_en, valu_op_en, vlsu_op_en, illegal_err, busy;
  logic [7:0] vmtx_opcode, valu_opcode, vlsu_opcode;
  logic [4:0] vmtx_vs1, vmtx_vs2, valu_vs1, valu_vs2, valu_rd, vlsu_vs1, vlsu_vs2, vlsu_rd;
`ifdef TOY_VDISPATCH_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  toy_vdispatch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit), .in_opcode(in_opcode),
    .in_vs1(in_vs1), .in_vs2(in_vs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr), .flush(flush),
    .vmtx_op_en(vmtx_op_en), .vmtx_opcode(vmtx_opcode), .vmtx_vs1(vmtx_vs1), .vmtx_vs2(vmtx_vs2),
    .valu_op_en(valu_op_en), .valu_opcode(valu_opcode), .valu_vs1(valu_vs1), .valu_vs2(valu_vs2),
    .valu_rd(valu_rd),
    .vlsu_op_en(vlsu_op_en), .vlsu_opcode(vlsu_opcode), .vlsu_vs1(vlsu_vs1), .vlsu_vs2(vlsu_vs2),
    .vlsu_rd(vlsu_rd),
    .illegal_err(illegal_err), .busy(busy)
`ifdef TOY_VDISPATCH_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: instruction queue plus absolute "earliest readable decision cycle" per register.
  instr_t      mq[$];
  longint      ready_at [32];
  longint      mcyc;
  bit          e_mtx, e_alu, e_lsu, e_ill, e_busy;
  instr_t      b_mtx, b_alu, b_lsu;
  int unsigned p_iss, p_stl;
  bit          rdy_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t ins(input bit [1:0] u, input bit [7:0] o, input bit [4:0] a,
                                 input bit [4:0] b, input bit [4:0] d, input bit w);
    return '{unit: u, opc: o, vs1: a, vs2: b, rd: d, wr: w};
  endfunction

  function automatic bit mbz(input logic [4:0] r);
    return (r != 5'd0) && (ready_at[r] > mcyc);
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    mcyc = 0;
    {e_mtx, e_alu, e_lsu, e_ill, e_busy} = '0;
    b_mtx = '0; b_alu = '0; b_lsu = '0;
    p_iss = 0; p_stl = 0;
  endtask

  task automatic model_step(input bit v, input instr_t in, input bit fl);
    int unsigned sz0 = mq.size();
    instr_t h;
    bit haz;
    {e_mtx, e_alu, e_lsu, e_ill} = '0;
    if (fl) begin
      mq.delete();
      p_iss = 0; p_stl = 0;
    end else begin
      if (sz0 != 0) begin
        h = mq[0];
        if (h.unit == 2'd3) begin
          void'(mq.pop_front());
          e_ill = 1'b1;
        end else begin
          haz = mbz(h.vs1) || mbz(h.vs2) || ((h.unit != 2'd0) && h.wr && mbz(h.rd));
          if (haz) begin
            if (p_stl != 32'hffff_ffff) p_stl++;
          end else begin
            void'(mq.pop_front());
            if (p_iss != 32'hffff_ffff) p_iss++;
            case (h.unit)
              2'd0:    begin e_mtx = 1'b1; b_mtx = h; end
              2'd1:    begin e_alu = 1'b1; b_alu = h; end
              default: begin e_lsu = 1'b1; b_lsu = h; end
            endcase
            if ((h.unit != 2'd0) && h.wr && (h.rd != 5'd0))
              ready_at[h.rd] = mcyc + 1 + ((h.unit == 2'd1) ? ALU_LAT : LSU_LAT);
          end
        end
      end
      if (v && (sz0 < DEPTH)) mq.push_back(in);
    end
    mcyc++;
    e_busy = (mq.size() != 0);
    for (int r = 1; r < 32; r++) if (ready_at[r] > mcyc) e_busy = 1'b1;
  endtask

  task automatic compare_outputs();
    check("vmtx_op_en", vmtx_op_en, e_mtx);
    check("valu_op_en", valu_op_en, e_alu);
    check("vlsu_op_en", vlsu_op_en, e_lsu);
    check("illegal_err", illegal_err, e_ill);
    check("busy", busy, e_busy);
    check("vmtx_fields", {vmtx_opcode, vmtx_vs1, vmtx_vs2}, {b_mtx.opc, b_mtx.vs1, b_mtx.vs2});
    check("valu_fields", {valu_opcode, valu_vs1, valu_vs2, valu_rd},
          {b_alu.opc, b_alu.vs1, b_alu.vs2, b_alu.rd});
    check("vlsu_fields", {vlsu_opcode, vlsu_vs1, vlsu_vs2, vlsu_rd},
          {b_lsu.opc, b_lsu.vs1, b_lsu.vs2, b_lsu.rd});
`ifdef TOY_VDISPATCH_PERF_EN
    check("perf_issue_cnt", perf_issue_cnt, p_iss);
    check("perf_stall_cnt", perf_stall_cnt, p_stl);
`endif
  endtask

  // One clock cycle: drive, check in_ready, advance model, sample after the edge.
  task automatic step(input bit v, input instr_t in, input bit fl);
    in_valid = v; in_unit = in.unit; in_opcode = in.opc; in_vs1 = in.vs1;
    in_vs2 = in.vs2; in_rd = in.rd; in_rd_wr = in.wr; flush = fl;
    #1;
    rdy_s = in_ready;
    check("in_ready", in_ready, (mq.size() < DEPTH) && !fl);
    model_step(v, in, fl);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    step(1'b0, ins(2'd0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0), 1'b0);
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (busy && (k < 20)) begin idle(); k++; end
    check("quiet_timeout", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_en"}, {vmtx_op_en, valu_op_en, vlsu_op_en, illegal_err}, 4'b0);
    check({tag, "_fields"}, {vmtx_opcode, valu_opcode, vlsu_opcode, valu_rd, vlsu_rd}, '0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  vec_t tbl [19];
  int t_lsu, t_alu, n_en;
  logic [31:0] stl0;

  initial begin
    in_valid = 0; in_unit = 0; in_opcode = 0; in_vs1 = 0; in_vs2 = 0; in_rd = 0;
    in_rd_wr = 0; flush = 0;
    // {v, instr(unit,opc,vs1,vs2,rd,wr), flush, rdy, mtx, alu, lsu, ill, busy}
    tbl[0]  = '{1, ins(1, 8'h10, 10, 10, 1, 1), 0, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, ins(1, 8'h11, 11, 11, 2, 1), 0, 1, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, ins(1, 8'h12, 12, 12, 3, 1), 0, 1, 0, 1, 0, 0, 1};
    tbl[3]  = '{1, ins(1, 8'h13, 13, 13, 4, 1), 0, 1, 0, 1, 0, 0, 1};
    tbl[4]  = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 1, 0, 0, 1};
    tbl[5]  = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, ins(1, 8'h20, 20, 21, 0, 1), 0, 1, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, ins(1, 8'h21, 0, 0, 9, 0),   0, 1, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{1, ins(3, 8'hee, 1, 1, 1, 1),   0, 1, 0, 0, 0, 0, 1};
    tbl[11] = '{1, ins(1, 8'h22, 1, 2, 6, 1),   0, 1, 0, 0, 0, 1, 1};
    tbl[12] = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 1, 0, 0, 1};
    tbl[13] = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 0, 0, 0, 1};
    tbl[14] = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{1, ins(0, 8'h30, 3, 4, 7, 1),   0, 1, 0, 0, 0, 0, 1};
    tbl[16] = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{1, ins(2, 8'h40, 5, 6, 8, 1),   0, 1, 0, 0, 0, 0, 1};
    tbl[18] = '{0, ins(0, 8'h00, 0, 0, 0, 0),   0, 1, 0, 0, 1, 0, 1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Directed table: back-to-back ALU, rd=0 no-hazard, illegal drop, MTX/LSU issue.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].in, tbl[i].fl);
      check($sformatf("tbl%0d_rdy", i), rdy_s, tbl[i].e_rdy);
      check($sformatf("tbl%0d_en", i), {vmtx_op_en, valu_op_en, vlsu_op_en, illegal_err},
            {tbl[i].e_mtx, tbl[i].e_alu, tbl[i].e_lsu, tbl[i].e_ill});
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Load-use: LSU rd=5 then ALU vs1=5 issues exactly LSU_LAT+1 after the load.
    wait_quiet();
`ifdef TOY_VDISPATCH_PERF_EN
    stl0 = perf_stall_cnt;
`else
    stl0 = 32'd0;
`endif
    t_lsu = -1; t_alu = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      step(1, ins(2, 8'h41, 0, 0, 5, 1), 0);
      else if (i == 1) step(1, ins(1, 8'h23, 5, 0, 10, 1), 0);
      else             idle();
      if (vlsu_op_en && t_lsu < 0) t_lsu = i;
      if (valu_op_en && t_alu < 0) t_alu = i;
    end
    check("ld_use_lsu_cycle", t_lsu, 1);
    check("ld_use_alu_cycle", t_alu, 5);
`ifdef TOY_VDISPATCH_PERF_EN
    check("ld_use_stalls", perf_stall_cnt - stl0, 32'd3);
`endif

    // Full FIFO behind a stalled head: 5th push accepted only the cycle after the first pop.
    wait_quiet();
    step(1, ins(2, 8'h42, 0, 0, 5, 1), 0);
    step(1, ins(1, 8'h24, 5, 0, 11, 1), 0);
    step(1, ins(1, 8'h25, 20, 21, 12, 1), 0);
    step(1, ins(1, 8'h26, 20, 21, 13, 1), 0);
    step(1, ins(1, 8'h27, 20, 21, 14, 1), 0);
    step(1, ins(1, 8'h28, 20, 21, 15, 1), 0);
    check("full_in_ready_low", rdy_s, 1'b0);
    check("full_head_pops", valu_op_en, 1'b1);
    step(1, ins(1, 8'h28, 20, 21, 15, 1), 0);
    check("full_5th_accept", rdy_s, 1'b1);
    wait_quiet();

    // Flush with three dependents queued behind ALU rd=7.
    step(1, ins(1, 8'h50, 1, 2, 7, 1), 0);
    step(1, ins(1, 8'h51, 7, 3, 13, 1), 0);
    step(1, ins(1, 8'h52, 7, 3, 14, 1), 0);
    step(1, ins(1, 8'h53, 7, 3, 15, 1), 0);
    check("pre_flush_stalled", valu_op_en, 1'b0);
    step(1, ins(1, 8'h54, 7, 3, 16, 1), 1);
    check("flush_in_ready", rdy_s, 1'b0);
    check("flush_busy", busy, 1'b0);
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      n_en += int'(vmtx_op_en) + int'(valu_op_en) + int'(vlsu_op_en);
    end
    check("post_flush_no_issue", n_en, 0);

    // Random traffic over a small register set to force frequent hazards.
    for (int i = 0; i < 800; i++) begin
      int unsigned r = $urandom_range(0, 15);
      bit [1:0] u = (r == 0) ? 2'd3 : (r < 4) ? 2'd0 : (r < 10) ? 2'd1 : 2'd2;
      step($urandom_range(0, 3) != 0,
           ins(u, 8'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom)),
           $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step(1, ins(2, 8'h60, 0, 0, 5'(i + 1), 1), 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
`ifdef TOY_VDISPATCH_PERF_EN
    check("async_reset_perf", {perf_issue_cnt, perf_stall_cnt}, 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 1) != 0,
           ins(2'($urandom_range(0, 2)), 8'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom)), 1'b0);
    end

    in_valid = 1'b0;
    flush = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
